// File: rtl/spart_fifo_if.sv
// Processor-side bus and serial pins of spart_fifo.
// databus stays a plain inout port on the module so that its tristate resolves cleanly.
interface spart_fifo_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;
  logic       txd;
  logic       rxd;

  modport slave (
    input  iocs,
    input  iorw,
    input  ioaddr,
    input  rxd,
    output rda,
    output tbr,
    output txd
  );

  modport master (
    output iocs,
    output iorw,
    output ioaddr,
    output rxd,
    input  rda,
    input  tbr,
    input  txd
  );
endinterface

// File: rtl/spart_fifo.sv
// Buffered UART-style serial port with parity, loopback and sticky error flags on an
// 8-bit iocs/iorw/ioaddr/databus processor bus.
module spart_fifo #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd324
) (
  input  logic        clk,
  input  logic        rst,
  spart_fifo_if.slave bus,
  inout  wire  [7:0]  databus
);

  localparam int unsigned AddrW   = $clog2(FIFO_DEPTH);
  localparam logic [2:0]  LastBit = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  logic                 rd_en, wr_en, st_rd, flush, div_wr;
  logic [1:0]           parity_q;
  logic                 loop_q;
  logic [15:0]          div_q, div_d, baud_cnt_q;
  logic                 tick, par_en, par_odd;
  logic [7:0]           rdata, status;

  logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [AddrW:0]       tx_wptr_q, tx_rptr_q;
  logic                 tx_empty, tx_full, tx_push, tx_pop;
  logic [DATA_BITS-1:0] tx_head;

  logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
  logic [AddrW:0]       rx_wptr_q, rx_rptr_q;
  logic                 rx_empty, rx_full, rx_push, rx_wr, rx_pop;
  logic [DATA_BITS-1:0] rx_head;

  state_e               tx_state_q;
  logic                 tx_hold_q, tx_line_q, tx_par_q, tx_pen_q;
  logic [3:0]           tx_tcnt_q;
  logic [2:0]           tx_bcnt_q;
  logic [DATA_BITS-1:0] tx_shift_q;

  state_e               rx_state_q;
  logic                 rx_s1_q, rx_s2_q, rx_prev_q, rx_in;
  logic                 rx_pen_q, rx_odd_q, rx_pbad_q, rx_samp_stop;
  logic [3:0]           rx_cnt_q;
  logic [2:0]           rx_bcnt_q;
  logic [DATA_BITS-1:0] rx_shift_q;

  logic                 rda_q, tbr_q, parity_err_q, frame_err_q, overrun_q;
  logic                 par_set, frame_set, ovr_set;

  // Bus decode
  assign rd_en  = bus.iocs && bus.iorw;
  assign wr_en  = bus.iocs && !bus.iorw;
  assign st_rd  = rd_en && (bus.ioaddr == 2'b01);
  assign flush  = wr_en && (bus.ioaddr == 2'b01) && databus[7];
  assign div_wr = wr_en && bus.ioaddr[1];

  assign databus = rd_en ? rdata : 8'bz;

  assign status = {tx_state_q != StIdle, overrun_q, frame_err_q, parity_err_q,
                   tx_empty, rx_full, tbr_q, rda_q};

  always_comb begin
    rdata = 8'h00;
    case (bus.ioaddr)
      2'b00:   if (!rx_empty) rdata = 8'(rx_head);
      2'b01:   rdata = status;
      2'b10:   rdata = div_q[7:0];
      default: rdata = div_q[15:8];
    endcase
  end

  always_comb begin
    div_d = div_q;
    if (div_wr) begin
      if (bus.ioaddr[0]) div_d[15:8] = databus;
      else               div_d[7:0]  = databus;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 2'b00;
      loop_q   <= 1'b0;
      div_q    <= DIV_RESET;
    end else begin
      div_q <= div_d;
      if (wr_en && (bus.ioaddr == 2'b01)) begin
        parity_q <= databus[1:0];
        loop_q   <= databus[2];
      end
    end
  end

  assign par_en  = (parity_q == 2'b01) || (parity_q == 2'b10);
  assign par_odd = (parity_q == 2'b10);

  // Baud generator: a divisor write restarts the count from the new value at once.
  assign tick = (baud_cnt_q == 16'd0);

  always_ff @(posedge clk) begin
    if (rst)         baud_cnt_q <= DIV_RESET;
    else if (div_wr) baud_cnt_q <= div_d;
    else if (tick)   baud_cnt_q <= div_q;
    else             baud_cnt_q <= baud_cnt_q - 16'd1;
  end

  // TX FIFO
  assign tx_empty = (tx_wptr_q == tx_rptr_q);
  assign tx_full  = (tx_wptr_q[AddrW] != tx_rptr_q[AddrW]) &&
                    (tx_wptr_q[AddrW-1:0] == tx_rptr_q[AddrW-1:0]);
  assign tx_push  = wr_en && (bus.ioaddr == 2'b00) && !tx_full;
  assign tx_head  = tx_mem[tx_rptr_q[AddrW-1:0]];

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr_q[AddrW-1:0]] <= databus[DATA_BITS-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
    end else begin
      if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + 1'b1;
    end
  end

  // RX FIFO: a push into a full FIFO still lands if the head is popped in the same cycle.
  assign rx_empty = (rx_wptr_q == rx_rptr_q);
  assign rx_full  = (rx_wptr_q[AddrW] != rx_rptr_q[AddrW]) &&
                    (rx_wptr_q[AddrW-1:0] == rx_rptr_q[AddrW-1:0]);
  assign rx_pop   = rd_en && (bus.ioaddr == 2'b00) && !rx_empty;
  assign rx_wr    = rx_push && (!rx_full || rx_pop);
  assign rx_head  = rx_mem[rx_rptr_q[AddrW-1:0]];

  always_ff @(posedge clk) begin
    if (rx_wr) rx_mem[rx_wptr_q[AddrW-1:0]] <= rx_shift_q;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
    end else begin
      if (rx_wr)  rx_wptr_q <= rx_wptr_q + 1'b1;
      if (rx_pop) rx_rptr_q <= rx_rptr_q + 1'b1;
    end
  end

  // Pop on entry to a frame from idle, or at the end of a stop bit for a gapless follow-on.
  assign tx_pop = !tx_empty && !flush &&
                  (((tx_state_q == StIdle) && !tx_hold_q) ||
                   ((tx_state_q == StStop) && tick && (tx_tcnt_q == 4'd15)));

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      tx_state_q <= StIdle;
      tx_hold_q  <= 1'b0;
      tx_line_q  <= 1'b1;
      tx_par_q   <= 1'b0;
      tx_pen_q   <= 1'b0;
      tx_tcnt_q  <= 4'd0;
      tx_bcnt_q  <= 3'd0;
      tx_shift_q <= '0;
    end else begin
      if (tx_pop) begin
        tx_shift_q <= tx_head;
        tx_par_q   <= (^tx_head) ^ par_odd;
        tx_pen_q   <= par_en;
      end
      if (tx_state_q == StIdle) begin
        if (tx_pop) begin
          tx_hold_q <= 1'b1;
        end else if (tx_hold_q && tick) begin
          tx_hold_q  <= 1'b0;
          tx_state_q <= StStart;
          tx_line_q  <= 1'b0;
          tx_tcnt_q  <= 4'd0;
        end
      end else if (tick) begin
        tx_tcnt_q <= tx_tcnt_q + 4'd1;
        if (tx_tcnt_q == 4'd15) begin
          case (tx_state_q)
            StStart: begin
              tx_state_q <= StData;
              tx_line_q  <= tx_shift_q[0];
              tx_bcnt_q  <= 3'd0;
            end
            StData: begin
              if (tx_bcnt_q == LastBit) begin
                tx_state_q <= tx_pen_q ? StParity : StStop;
                tx_line_q  <= tx_pen_q ? tx_par_q : 1'b1;
              end else begin
                tx_bcnt_q  <= tx_bcnt_q + 3'd1;
                tx_shift_q <= tx_shift_q >> 1;
                tx_line_q  <= tx_shift_q[1];
              end
            end
            StParity: begin
              tx_state_q <= StStop;
              tx_line_q  <= 1'b1;
            end
            default: begin
              tx_state_q <= tx_pop ? StStart : StIdle;
              tx_line_q  <= !tx_pop;
            end
          endcase
        end
      end
    end
  end

  // Loopback feeds the receiver straight from the TX line, skipping the synchroniser.
  assign rx_in = loop_q ? tx_line_q : rx_s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= bus.rxd;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_in;
    end
  end

  // Only a falling edge re-arms, so a low line after a framing error is ignored.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rx_state_q <= StIdle;
      rx_cnt_q   <= 4'd0;
      rx_bcnt_q  <= 3'd0;
      rx_shift_q <= '0;
      rx_pen_q   <= 1'b0;
      rx_odd_q   <= 1'b0;
      rx_pbad_q  <= 1'b0;
    end else if (rx_state_q == StIdle) begin
      if (rx_prev_q && !rx_in) begin
        rx_state_q <= StStart;
        rx_cnt_q   <= 4'd0;
        rx_pen_q   <= par_en;
        rx_odd_q   <= par_odd;
        rx_pbad_q  <= 1'b0;
      end
    end else if (tick) begin
      rx_cnt_q <= rx_cnt_q + 4'd1;
      case (rx_state_q)
        StStart: begin
          if ((rx_cnt_q == 4'd7) && rx_in) begin
            rx_state_q <= StIdle;
          end else if (rx_cnt_q == 4'd15) begin
            rx_state_q <= StData;
            rx_bcnt_q  <= 3'd0;
          end
        end
        StData: begin
          if (rx_cnt_q == 4'd7) rx_shift_q <= {rx_in, rx_shift_q[DATA_BITS-1:1]};
          if (rx_cnt_q == 4'd15) begin
            if (rx_bcnt_q == LastBit) rx_state_q <= rx_pen_q ? StParity : StStop;
            else                      rx_bcnt_q  <= rx_bcnt_q + 3'd1;
          end
        end
        StParity: begin
          if (rx_cnt_q == 4'd7)  rx_pbad_q  <= rx_in ^ (^rx_shift_q) ^ rx_odd_q;
          if (rx_cnt_q == 4'd15) rx_state_q <= StStop;
        end
        default: begin
          if (rx_cnt_q == 4'd7) rx_state_q <= StIdle;
        end
      endcase
    end
  end

  assign rx_samp_stop = (rx_state_q == StStop) && tick && (rx_cnt_q == 4'd7);
  assign rx_push      = rx_samp_stop && rx_in;
  assign frame_set    = rx_samp_stop && !rx_in;
  assign par_set      = rx_push && rx_pbad_q;
  assign ovr_set      = rx_push && rx_full && !rx_pop;

  // Error flags: a status read clears them, a fresh error in the same cycle wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      rda_q        <= 1'b0;
      tbr_q        <= 1'b1;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rda_q        <= !rx_empty;
      tbr_q        <= !tx_full;
      parity_err_q <= par_set   || (parity_err_q && !st_rd);
      frame_err_q  <= frame_set || (frame_err_q && !st_rd);
      overrun_q    <= ovr_set   || (overrun_q && !st_rd);
    end
  end

  assign bus.rda = rda_q;
  assign bus.tbr = tbr_q;
  assign bus.txd = loop_q ? 1'b1 : tx_line_q;

endmodule

// File: tb/tb_spart_fifo.sv
// Directed bench for spart_fifo: register vector table plus serial corner-case sequences,
// with a second DATA_BITS=5 instance for the truncation case.
module tb_spart_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       iocs = 1'b0;
  logic       iorw = 1'b0;
  logic [1:0] ioaddr = 2'b00;
  logic       rxd = 1'b1;
  logic       sel = 1'b0;
  logic       drv_en = 1'b0;
  logic [7:0] drv = 8'h00;
  logic [7:0] rd;
  wire  [7:0] db8;
  wire  [7:0] db5;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  spart_fifo_if bus8 ();
  spart_fifo_if bus5 ();

  assign bus8.iocs   = iocs && !sel;
  assign bus8.iorw   = iorw;
  assign bus8.ioaddr = ioaddr;
  assign bus8.rxd    = rxd;
  assign bus5.iocs   = iocs && sel;
  assign bus5.iorw   = iorw;
  assign bus5.ioaddr = ioaddr;
  assign bus5.rxd    = rxd;

  assign db8 = (drv_en && !sel) ? drv : 8'bz;
  assign db5 = (drv_en && sel) ? drv : 8'bz;

  spart_fifo #(.DATA_BITS(8), .FIFO_DEPTH(8), .DIV_RESET(16'd324)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus8),
    .databus (db8)
  );

  spart_fifo #(.DATA_BITS(5), .FIFO_DEPTH(8), .DIV_RESET(16'd324)) u_dut5 (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus5),
    .databus (db5)
  );

  typedef struct packed {
    logic       wr;
    logic [1:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, want 0x%02h", name, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b0; ioaddr = a; drv = d; drv_en = 1'b1;
    @(negedge clk);
    iocs = 1'b0; drv_en = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b1; ioaddr = a;
    #1;
    d = sel ? db5 : db8;
    @(negedge clk);
    iocs = 1'b0; iorw = 1'b0;
  endtask

  // One bit = 16 clocks at divisor 0.
  task automatic drive_bit(input logic b);
    rxd = b;
    repeat (16) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                            input logic stopb);
    @(negedge clk);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (pen) drive_bit(pbit);
    drive_bit(stopb);
    rxd = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int txd_low;
    int seen;

    vecs[0]  = '{1'b0, 2'b01, 8'h00, 8'h0A};
    vecs[1]  = '{1'b0, 2'b10, 8'h00, 8'h44};
    vecs[2]  = '{1'b0, 2'b11, 8'h00, 8'h01};
    vecs[3]  = '{1'b0, 2'b00, 8'h00, 8'h00};
    vecs[4]  = '{1'b1, 2'b10, 8'hA5, 8'h00};
    vecs[5]  = '{1'b0, 2'b10, 8'h00, 8'hA5};
    vecs[6]  = '{1'b1, 2'b11, 8'h3C, 8'h00};
    vecs[7]  = '{1'b0, 2'b11, 8'h00, 8'h3C};
    vecs[8]  = '{1'b1, 2'b10, 8'h00, 8'h00};
    vecs[9]  = '{1'b1, 2'b11, 8'h00, 8'h00};
    vecs[10] = '{1'b0, 2'b10, 8'h00, 8'h00};
    vecs[11] = '{1'b0, 2'b11, 8'h00, 8'h00};
    vecs[12] = '{1'b0, 2'b01, 8'h00, 8'h0A};

    // Single-cycle reset pulse
    @(negedge clk);
    rst = 1'b0;
    check("reset_txd", 8'(bus8.txd), 8'h01);
    check("reset_rda", 8'(bus8.rda), 8'h00);
    check("reset_tbr", 8'(bus8.tbr), 8'h01);

    // Register vectors; leaves the divisor at 0
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].wr) begin
        bus_wr(vecs[i].addr, vecs[i].data);
      end else begin
        bus_rd(vecs[i].addr, rd);
        check($sformatf("reg_vec%0d", i), rd, vecs[i].exp);
      end
    end

    // Loopback
    bus_wr(2'b01, 8'h04);
    bus_wr(2'b00, 8'hA6);
    txd_low = 0;
    seen = 0;
    for (int i = 0; i < 179 && seen == 0; i++) begin
      @(negedge clk);
      if (!bus8.txd) txd_low++;
      if (bus8.rda) seen = 1;
    end
    check("loop_rda_rise", 8'(seen), 8'h01);
    check("loop_ext_txd_low_cycles", 8'(txd_low), 8'h00);
    bus_rd(2'b00, rd);
    check("loop_data", rd, 8'hA6);
    bus_rd(2'b00, rd);
    check("loop_empty_read", rd, 8'h00);
    bus_wr(2'b01, 8'h00);

    // Even parity with a wrong parity bit
    bus_wr(2'b01, 8'h01);
    send_frame(8'h59, 1'b1, 1'b1, 1'b1);
    bus_rd(2'b00, rd);
    check("parity_data", rd, 8'h59);
    bus_rd(2'b01, rd);
    check("parity_status_set", rd, 8'h1A);
    bus_rd(2'b01, rd);
    check("parity_status_clr", rd, 8'h0A);
    bus_wr(2'b01, 8'h00);

    // Framing error, then a clean frame
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    check("frame_rda", 8'(bus8.rda), 8'h00);
    bus_rd(2'b01, rd);
    check("frame_status", rd, 8'h2A);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    bus_rd(2'b00, rd);
    check("frame_next_data", rd, 8'h3C);

    // Overrun and pointer wrap, two rounds
    for (int r = 0; r < 2; r++) begin
      for (int f = 1; f <= 9; f++) send_frame(8'(f), 1'b0, 1'b0, 1'b1);
      bus_rd(2'b01, rd);
      check($sformatf("ovr_status_r%0d", r), rd, 8'h4F);
      for (int k = 1; k <= 8; k++) begin
        bus_rd(2'b00, rd);
        check($sformatf("ovr_data_r%0d_%0d", r, k), rd, 8'(k));
      end
      @(negedge clk);
      check($sformatf("ovr_rda_r%0d", r), 8'(bus8.rda), 8'h00);
      bus_rd(2'b00, rd);
      check($sformatf("ovr_empty_r%0d", r), rd, 8'h00);
    end

    // Reset during the data bits of a frame
    bus_wr(2'b00, 8'h55);
    repeat (40) @(negedge clk);
    check("abort_mid_data_txd", 8'(bus8.txd), 8'h00);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_txd", 8'(bus8.txd), 8'h01);
    bus_rd(2'b01, rd);
    check("abort_status", rd, 8'h0A);
    txd_low = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!bus8.txd) txd_low++;
    end
    check("abort_no_frame", 8'(txd_low), 8'h00);

    // DATA_BITS=5 instance: truncation on write, zero-extension on read
    sel = 1'b1;
    bus_wr(2'b10, 8'h00);
    bus_wr(2'b11, 8'h00);
    bus_wr(2'b01, 8'h04);
    bus_wr(2'b00, 8'hFF);
    seen = 0;
    for (int i = 0; i < 200 && seen == 0; i++) begin
      @(negedge clk);
      if (bus5.rda) seen = 1;
    end
    check("db5_rda_rise", 8'(seen), 8'h01);
    bus_rd(2'b00, rd);
    check("db5_data", rd, 8'h1F);
    sel = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
